// File: rtl/aes_io_pkg.sv
// -----------------------------------------------------------------------------
// aes_io_pkg
// Shared types and constants for the AES operand loader.
//   AES_W          : width of one AES operand (key or ciphertext block)
//   loader_state_t : loader FSM states
// -----------------------------------------------------------------------------
package aes_io_pkg;

  localparam int AES_W = 128;

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_MSG,
    ARMED,
    DONE
  } loader_state_t;

endpackage

// File: rtl/aes_word_shifter.sv
// -----------------------------------------------------------------------------
// aes_word_shifter
// Assembles an AES_W-bit operand from a stream of WORD_W-bit words. Each
// enabled cycle shifts the register left by one word and appends din, so the
// first word received ends up in the most-significant position.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset, clears the operand
//   en      : shift in din this cycle
//   din     : incoming word
//   q       : assembled operand
// -----------------------------------------------------------------------------
module aes_word_shifter #(
  parameter int WORD_W = 32,
  parameter int AES_W  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [AES_W-1:0]  q
);

  // Operand register: cleared on reset, shifted by one word per accepted
  // transfer, otherwise held so the value stays frozen once loading ends.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[AES_W-WORD_W-1:0], din};
    end
  end

endmodule

// File: rtl/aes_io_loader.sv
// -----------------------------------------------------------------------------
// aes_io_loader
// Upstream feeder for aes_controller. Collects WORDS key words followed by
// WORDS ciphertext words over a valid/ready handshake, then raises io_ready
// and holds both operands stable until aes_ready reports completion.
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : synchronous active-low reset
//   in_data   : input word, most-significant word first
//   in_valid  : in_data valid this cycle
//   in_ready  : loader accepts a word this cycle
//   key       : assembled 128-bit cipher key
//   msg_en    : assembled 128-bit ciphertext
//   io_ready  : operands complete and stable, starts the AES run
//   aes_ready : completion flag from aes_controller
//   busy      : high from the first accepted word until DONE
//   done      : decryption finished (terminal until reset)
// -----------------------------------------------------------------------------
module aes_io_loader
  import aes_io_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [AES_W-1:0]  key,
  output logic [AES_W-1:0]  msg_en,
  output logic              io_ready,
  input  logic              aes_ready,
  output logic              busy,
  output logic              done
);

  localparam int WORDS = AES_W / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  loader_state_t    state_q;
  loader_state_t    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load_phase;
  logic             xfer;
  logic             last_word;

  // in_ready decodes from the state register only; reset_n gates it so no
  // word is handshaken while reset is held.
  assign load_phase = (state_q == LOAD_KEY) || (state_q == LOAD_MSG);
  assign in_ready   = reset_n && load_phase;
  assign xfer       = in_valid && in_ready;
  assign last_word  = (cnt_q == LAST_CNT);

  assign busy = ((state_q == LOAD_KEY) && (cnt_q != '0)) ||
                (state_q == LOAD_MSG) || (state_q == ARMED);

  // State register and word counter. The counter wraps on the last word of
  // each operand, so it restarts at zero for the ciphertext phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD_KEY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        cnt_q <= last_word ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Next-state and Moore outputs. aes_ready only matters once armed, and
  // DONE is terminal until reset.
  always_comb begin
    state_d  = state_q;
    io_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      LOAD_KEY: if (xfer && last_word) state_d = LOAD_MSG;
      LOAD_MSG: if (xfer && last_word) state_d = ARMED;
      ARMED: begin
        io_ready = 1'b1;
        if (aes_ready) state_d = DONE;
      end
      DONE:    done = 1'b1;
      default: state_d = LOAD_KEY;
    endcase
  end

  aes_word_shifter #(
    .WORD_W (WORD_W),
    .AES_W  (AES_W)
  ) u_key_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (xfer && (state_q == LOAD_KEY)),
    .din     (in_data),
    .q       (key)
  );

  aes_word_shifter #(
    .WORD_W (WORD_W),
    .AES_W  (AES_W)
  ) u_msg_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (xfer && (state_q == LOAD_MSG)),
    .din     (in_data),
    .q       (msg_en)
  );

endmodule

// File: tb/tb_aes_io_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_io_loader
// Self-checking bench for aes_io_loader: a 32-bit-word instance exercised by
// directed and randomized load sequences, and an 8-bit-word instance loaded
// with the FIPS-197 byte stream.
// -----------------------------------------------------------------------------
module tb_aes_io_loader;

  localparam int WORDS32 = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_MSG = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         reset_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] msg_en;
  logic         io_ready;
  logic         aes_ready;
  logic         busy;
  logic         done;

  logic [7:0]   b_in_data;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [127:0] b_key;
  logic [127:0] b_msg_en;
  logic         b_io_ready;
  logic         b_aes_ready;
  logic         b_busy;
  logic         b_done;

  int total;
  int bad;
  logic [31:0] stim_q[$];

  aes_io_loader #(.WORD_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .msg_en    (msg_en),
    .io_ready  (io_ready),
    .aes_ready (aes_ready),
    .busy      (busy),
    .done      (done)
  );

  aes_io_loader #(.WORD_W(8)) dut_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .key       (b_key),
    .msg_en    (b_msg_en),
    .io_ready  (b_io_ready),
    .aes_ready (b_aes_ready),
    .busy      (b_busy),
    .done      (b_done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted always, reported and counted as bad on mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference operand: word i of the operand lands at bits
  // [127-32*i -: 32], i.e. first word most significant.
  function automatic logic [127:0] modelOperand(input int first);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < WORDS32; i++) r[127-32*i -: 32] = stim_q[first+i];
    return r;
  endfunction

  // Hold reset for one edge, check cleared outputs, then release. Returns
  // just after release, in the first cycle out of reset.
  task automatic applyReset();
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    aes_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_aes_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_key", key, '0);
    checkOutput("rst_msg", msg_en, '0);
    checkOutput("rst_io_ready", io_ready, '0);
    checkOutput("rst_busy", busy, '0);
    checkOutput("rst_done", done, '0);
    checkOutput("rst_in_ready", in_ready, '0);
    checkOutput("rst_b_key", b_key, '0);
    reset_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", in_ready, 1);
    checkOutput("rel_busy", busy, 0);
  endtask

  // Stream the 8 words of stim_q into the 32-bit DUT. valid_mode:
  // 0 = held high, 1 = toggling starting low, 2 = random. The model tracks
  // only the count of accepted words; handshake outputs follow from it.
  // Reports the cycle (1 = first after reset release) where io_ready is seen.
  task automatic applyStimulus(input int valid_mode, input bit hold_aes,
                               output int rise_cycle);
    int  n;
    int  cyc;
    int  last_xfer;
    bit  v;
    n = 0;
    cyc = 0;
    last_xfer = 0;
    rise_cycle = -1;
    while (cyc < 200 && rise_cycle < 0) begin
      cyc++;
      checkOutput("ld_in_ready", in_ready, n < 2*WORDS32);
      checkOutput("ld_io_ready", io_ready, n == 2*WORDS32);
      checkOutput("ld_busy", busy, n > 0);
      checkOutput("ld_done", done, 0);
      if (n == 2*WORDS32) begin
        rise_cycle = cyc;
      end else begin
        case (valid_mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 0;
          default: v = $urandom_range(0, 1) == 1;
        endcase
        in_valid  = v;
        in_data   = v ? stim_q[n] : $urandom;
        aes_ready = hold_aes ? 1'b1 : 1'(($urandom_range(0, 1)));
        @(posedge clk);
        if (v) begin
          n++;
          last_xfer = cyc;
        end
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    aes_ready = 1'b0;
    checkOutput("ld_completed", rise_cycle > 0, 1);
    checkOutput("ld_rise_vs_model", rise_cycle, last_xfer + 1);
    checkOutput("ld_key", key, modelOperand(0));
    checkOutput("ld_msg", msg_en, modelOperand(WORDS32));
  endtask

  initial begin
    int rise;
    int nb;
    int bcyc;
    int brise;
    logic [127:0] held_key;
    logic [255:0] bytes;
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    aes_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_aes_ready = 1'b0;
    @(negedge clk);

    $display("[TB] FIPS-197 load, valid held high");
    applyReset();
    stim_q = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
               32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    applyStimulus(0, 1'b0, rise);
    checkOutput("fips_rise_cycle", rise, 9);
    checkOutput("fips_key", key, FIPS_KEY);
    checkOutput("fips_msg", msg_en, FIPS_MSG);

    $display("[TB] words offered while armed are ignored");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hdeadbeef;
      @(posedge clk);
      @(negedge clk);
      checkOutput("armed_msg", msg_en, FIPS_MSG);
      checkOutput("armed_key", key, FIPS_KEY);
      checkOutput("armed_io_ready", io_ready, 1);
      checkOutput("armed_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    $display("[TB] completion pulse");
    aes_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aes_ready = 1'b0;
    checkOutput("cmp_io_ready", io_ready, 0);
    checkOutput("cmp_done", done, 1);
    checkOutput("cmp_busy", busy, 0);
    for (int i = 0; i < 24; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      aes_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_done", done, 1);
      checkOutput("hold_io_ready", io_ready, 0);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_msg", msg_en, FIPS_MSG);
    end

    $display("[TB] throttled source");
    applyReset();
    applyStimulus(1, 1'b0, rise);
    checkOutput("thr_rise_cycle", rise, 17);
    checkOutput("thr_key", key, FIPS_KEY);
    checkOutput("thr_msg", msg_en, FIPS_MSG);

    $display("[TB] aes_ready held during load");
    applyReset();
    applyStimulus(0, 1'b1, rise);
    checkOutput("aesh_rise_cycle", rise, 9);
    @(posedge clk);
    @(negedge clk);
    checkOutput("aesh_still_armed", io_ready, 1);
    checkOutput("aesh_not_done", done, 0);

    $display("[TB] reset mid-load");
    applyReset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = stim_q[i];
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("mid_busy", busy, 1);
    applyReset();
    applyStimulus(2, 1'b0, rise);
    checkOutput("mid_reload_key", key, FIPS_KEY);
    checkOutput("mid_reload_msg", msg_en, FIPS_MSG);

    $display("[TB] random operands, random valid");
    for (int t = 0; t < 3; t++) begin
      applyReset();
      stim_q.delete();
      for (int i = 0; i < 2*WORDS32; i++) stim_q.push_back($urandom);
      applyStimulus(2, 1'b0, rise);
    end

    $display("[TB] byte-wide instance");
    applyReset();
    bytes = {FIPS_KEY, FIPS_MSG};
    nb    = 0;
    bcyc  = 0;
    brise = -1;
    while (bcyc < 100 && brise < 0) begin
      bcyc++;
      if (b_io_ready) begin
        brise = bcyc;
      end else begin
        checkOutput("b_in_ready", b_in_ready, nb < 32);
        b_in_valid = 1'b1;
        b_in_data  = bytes[255-8*nb -: 8];
        @(posedge clk);
        nb++;
        @(negedge clk);
      end
    end
    b_in_valid = 1'b0;
    checkOutput("b_rise_cycle", brise, 33);
    checkOutput("b_key", b_key, FIPS_KEY);
    checkOutput("b_msg", b_msg_en, FIPS_MSG);
    held_key = b_key;
    b_aes_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_aes_ready = 1'b0;
    checkOutput("b_done", b_done, 1);
    checkOutput("b_key_held", b_key, FIPS_KEY);
    checkOutput("b_key_stable", held_key, FIPS_KEY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
